// File: rtl/qnigma_pkg.sv
// Shared TCP window-scaling types and constants for the window scalers.
package qnigma_pkg;

  localparam int          TCP_W       = 32;
  localparam int          TCP_MAX_WS  = 14;
  localparam logic [15:0] TCP_WND_MAX = 16'hFFFF;

  typedef logic [3:0]       tcp_scl_t;
  typedef logic [TCP_W-1:0] tcp_wnd_scl_t;

  typedef enum logic [1:0] {
    WA_IDLE,
    WA_SWS,
    WA_SHIFT,
    WA_SAT
  } tcp_wnd_adv_fsm_t;

  function automatic tcp_scl_t clamp_scl(input tcp_scl_t s);
    return (s > 4'(TCP_MAX_WS)) ? 4'(TCP_MAX_WS) : s;
  endfunction

endpackage

// File: rtl/qnigma_tcp_wnd_adv.sv
// Converts free RX buffer bytes into the scaled 16-bit TCP window field, with
// receiver SWS avoidance when QNIGMA_TCP_WND_SWS_EN is defined.
module qnigma_tcp_wnd_adv
  import qnigma_pkg::*;
#(
  parameter int BUF_SIZE = 65536,
  parameter int W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_scl,
  input  logic [3:0]   scl,
  input  logic [15:0]  mss,
  input  logic         upd,
  input  logic [W-1:0] free,
  output logic [15:0]  wnd,
  output logic         val,
  output logic         busy,
  output logic         wnd_upd
);

  localparam logic [W-1:0] HALF_BUF = W'(BUF_SIZE / 2);

  tcp_wnd_adv_fsm_t state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     adv_q, adv_d;
  tcp_scl_t         ctr_q, ctr_d;
  tcp_scl_t         scl_q, scl_d;
  logic             pend_q, pend_d;
  logic [15:0]      wnd_q, wnd_d;
  logic             val_q, val_d;
  logic             busy_q, busy_d;
  logic             wupd_q, wupd_d;

  logic [W-1:0]     mss_w;
  logic [W-1:0]     thr;
  logic [15:0]      sat_wnd;
  logic [W-1:0]     adv_new;

  function automatic logic [15:0] sat16(input logic [W-1:0] a);
    return (a > W'(TCP_WND_MAX)) ? TCP_WND_MAX : a[15:0];
  endfunction

  // Reopen detection: did the advertised window cross from "closed" to "open"?
  function automatic logic reopened(input logic [W-1:0] old_adv,
                                    input logic [W-1:0] new_adv,
                                    input logic [W-1:0] th);
`ifdef QNIGMA_TCP_WND_SWS_EN
    return (old_adv < th) && (new_adv >= th);
`else
    return (old_adv == '0) && (new_adv != '0) && (th == th);
`endif
  endfunction

  assign mss_w   = {{(W-16){1'b0}}, mss};
  assign thr     = (mss_w < HALF_BUF) ? mss_w : HALF_BUF;
  assign sat_wnd = sat16(acc_q);
  assign adv_new = {{(W-16){1'b0}}, sat_wnd} << scl_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    adv_d   = adv_q;
    ctr_d   = ctr_q;
    scl_d   = scl_q;
    pend_d  = pend_q;
    wnd_d   = wnd_q;
    val_d   = 1'b0;
    busy_d  = busy_q;
    wupd_d  = 1'b0;

    if (upd && (state_q != WA_IDLE)) pend_d = 1'b1;

    case (state_q)
      WA_IDLE: begin
        if (set_scl) begin
          scl_d  = clamp_scl(scl);
          pend_d = pend_q | upd;
        end else if (upd || pend_q) begin
          acc_d   = free;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = WA_SWS;
        end
      end
      WA_SWS: begin
`ifdef QNIGMA_TCP_WND_SWS_EN
        // Hold the right edge until it can move by at least thr bytes.
        if ((acc_q > adv_q) && ((acc_q - adv_q) < thr)) acc_d = adv_q;
`endif
        ctr_d   = '0;
        state_d = (scl_q != '0) ? WA_SHIFT : WA_SAT;
      end
      WA_SHIFT: begin
        acc_d = acc_q >> 1;
        ctr_d = ctr_q + 4'd1;
        if (ctr_q == scl_q - 4'd1) state_d = WA_SAT;
      end
      WA_SAT: begin
        wnd_d   = sat_wnd;
        adv_d   = adv_new;
        val_d   = 1'b1;
        busy_d  = 1'b0;
        wupd_d  = reopened(adv_q, adv_new, thr);
        state_d = WA_IDLE;
      end
      default: state_d = WA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WA_IDLE;
      acc_q   <= '0;
      adv_q   <= '0;
      ctr_q   <= '0;
      scl_q   <= '0;
      pend_q  <= 1'b0;
      wnd_q   <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
      wupd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      adv_q   <= adv_d;
      ctr_q   <= ctr_d;
      scl_q   <= scl_d;
      pend_q  <= pend_d;
      wnd_q   <= wnd_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      wupd_q  <= wupd_d;
    end
  end

  assign wnd     = wnd_q;
  assign val     = val_q;
  assign busy    = busy_q;
  assign wnd_upd = wupd_q;

endmodule

// File: tb/tb_qnigma_tcp_wnd_adv.sv
// Bench for qnigma_tcp_wnd_adv: table vectors, random transactions against a
// byte-level window model, and hand sequences for upd collapsing and reset.
module tb_qnigma_tcp_wnd_adv;

  localparam int BUF = 65536;
  localparam int W   = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         set_scl = 1'b0;
  logic [3:0]   scl = '0;
  logic [15:0]  mss = 16'd1460;
  logic         upd = 1'b0;
  logic [W-1:0] free = '0;
  logic [15:0]  wnd;
  logic         val;
  logic         busy;
  logic         wnd_upd;

  int checks = 0;
  int fails  = 0;

  longint m_adv = 0;
  int     m_scl = 0;

  qnigma_tcp_wnd_adv #(.BUF_SIZE(BUF), .W(W)) dut (
    .clk(clk), .rst(rst), .set_scl(set_scl), .scl(scl), .mss(mss),
    .upd(upd), .free(free), .wnd(wnd), .val(val), .busy(busy),
    .wnd_upd(wnd_upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wnd_upd) begin
      checks++;
      if (!val) begin
        fails++;
        $display("FAIL wnd_upd_without_val: got val=%0d, expected 1", val);
      end
    end
  end

  // Window semantics in bytes: hold small openings, divide by 2^scale,
  // saturate to 16 bits, remember what was really advertised.
  function automatic void model(input longint fr, input int mss_v,
                                output longint ew, output bit eu);
    longint thr, a, na;
    thr = (mss_v < BUF / 2) ? mss_v : BUF / 2;
    a   = fr;
`ifdef QNIGMA_TCP_WND_SWS_EN
    if (a > m_adv && a - m_adv < thr) a = m_adv;
`endif
    a  = a / (longint'(1) << m_scl);
    ew = (a > 65535) ? 65535 : a;
    na = ew * (longint'(1) << m_scl);
`ifdef QNIGMA_TCP_WND_SWS_EN
    eu = (m_adv < thr) && (na >= thr);
`else
    eu = (m_adv == 0) && (na != 0);
`endif
    m_adv = na;
  endfunction

  task automatic run_upd(input string name, input bit ds, input int s,
                         input int ms, input longint fr,
                         input longint ew, input bit eu);
    int  lat, exp_lat;
    bit  got;
    exp_lat = ds ? (((s > 14) ? 14 : s) + 3) : (m_scl + 2);
    @(negedge clk);
    set_scl = ds; scl = 4'(s); mss = 16'(ms); free = W'(fr); upd = 1'b1;
    @(negedge clk);
    set_scl = 1'b0; upd = 1'b0;
    chk({name, "_busy"}, longint'(busy), longint'(!ds));
    got = 0; lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (val) begin got = 1; lat = k; end
    end
    if (!got) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_lat"}, lat, exp_lat);
      chk({name, "_wnd"}, longint'(wnd), ew);
      chk({name, "_wupd"}, longint'(wnd_upd), longint'(eu));
      chk({name, "_busy_done"}, longint'(busy), 0);
    end
  endtask

  typedef struct {
    bit     do_scl;
    int     s;
    int     ms;
    longint fr;
    longint ew;
    bit     eu;
  } vec_t;

  vec_t tbl[11];

  initial begin
    longint ew, e1, e2;
    bit     eu, dummy;
    int     nval, t1, t2;
    longint w1, w2, fr;
    int     s, ms;
    bit     ds;

    tbl[0]  = '{1'b1, 0,  1460, 40000,        40000, 1'b1};
`ifdef QNIGMA_TCP_WND_SWS_EN
    tbl[1]  = '{1'b0, 0,  1460, 40500,        40000, 1'b0};
`else
    tbl[1]  = '{1'b0, 0,  1460, 40500,        40500, 1'b0};
`endif
    tbl[2]  = '{1'b0, 0,  1460, 41500,        41500, 1'b0};
    tbl[3]  = '{1'b0, 0,  1460, 200000,       65535, 1'b0};
    tbl[4]  = '{1'b0, 0,  1460, 100,          100,   1'b0};
    tbl[5]  = '{1'b0, 0,  1460, 0,            0,     1'b0};
`ifdef QNIGMA_TCP_WND_SWS_EN
    tbl[6]  = '{1'b0, 0,  1460, 10,           0,     1'b0};
    tbl[7]  = '{1'b0, 0,  1460, 3000,         3000,  1'b1};
`else
    tbl[6]  = '{1'b0, 0,  1460, 10,           10,    1'b1};
    tbl[7]  = '{1'b0, 0,  1460, 3000,         3000,  1'b0};
`endif
    tbl[8]  = '{1'b1, 7,  1460, 1000000,      7812,  1'b0};
    tbl[9]  = '{1'b1, 15, 1460, 64'hFFFFFFFF, 65535, 1'b0};
    tbl[10] = '{1'b1, 3,  100,  50,           6,     1'b0};

    #12;
    chk("reset_wnd", longint'(wnd), 0);
    chk("reset_val", longint'(val), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_wupd", longint'(wnd_upd), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].do_scl) m_scl = (tbl[i].s > 14) ? 14 : tbl[i].s;
      model(tbl[i].fr, tbl[i].ms, ew, dummy);
      run_upd($sformatf("vec%0d", i), tbl[i].do_scl, tbl[i].s, tbl[i].ms,
              tbl[i].fr, tbl[i].ew, tbl[i].eu);
    end
    chk("adv_after_scl3", m_adv, 48);

    for (int i = 0; i < 40; i++) begin
      ds = ($urandom % 4) == 0;
      s  = $urandom_range(0, 15);
      ms = $urandom_range(1, 3000);
      case ($urandom % 4)
        0:       fr = m_adv + $urandom_range(0, 2000);
        1:       fr = $urandom_range(0, 200);
        2:       fr = longint'($urandom);
        default: fr = $urandom_range(0, 100000);
      endcase
      if (ds) m_scl = (s > 14) ? 14 : s;
      model(fr, ms, ew, eu);
      run_upd($sformatf("rnd%0d", i), ds, s, ms, fr, ew, eu);
    end

    // Three upd pulses during one scl=5 run collapse into a single rerun.
    m_scl = 5;
    model(70000, 1460, ew, eu);
    run_upd("coll_setup", 1'b1, 5, 1460, 70000, ew, eu);
    model(900000, 1460, e1, dummy);
    model(500000, 1460, e2, dummy);
    nval = 0; t1 = 0; t2 = 0; w1 = -1; w2 = -1;
    @(negedge clk);
    free = W'(900000); upd = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      upd = (k >= 2 && k <= 4);
      if (k == 1) free = W'(500000);
      @(posedge clk); #1;
      if (val) begin
        nval++;
        if (nval == 1) begin t1 = k; w1 = wnd; end
        if (nval == 2) begin t2 = k; w2 = wnd; end
      end
    end
    chk("coll_nval", nval, 2);
    chk("coll_t1", t1, 7);
    chk("coll_t2", t2, 15);
    chk("coll_w1", w1, e1);
    chk("coll_w2", w2, e2);

    // Reset while shifting: computation is abandoned, no val afterwards.
    @(negedge clk);
    free = W'(2000000); upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_wnd", longint'(wnd), 0);
    chk("rst_mid_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    nval = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (val) nval++;
    end
    chk("rst_no_val", nval, 0);
    m_adv = 0; m_scl = 0;
    model(500, 1460, ew, eu);
    run_upd("post_rst", 1'b0, 0, 1460, 500, ew, eu);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
